uart_rx_buf: RTL and testbench
==============================

Name: uart_rx_buf

Overview:
UART receive front-end and byte buffer that produces the core's 8-bit rxdata input. It oversamples the serial line (8N1, LSB first) and pushes each good byte into a small FIFO. The core's UART-read instruction pops one byte per read. Buffering lets back-to-back host bytes survive multicycle instruction latency.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal values >= 4.
DEPTH, 16, FIFO entries; power of 2, >= 2.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
rxd  input  1  asynchronous serial line; idle high
rx_data  output  8  head-of-FIFO byte (show-ahead); 8'h00 when empty
rx_valid  output  1  FIFO non-empty
rx_pop  input  1  consume head byte this cycle; ignored when rx_valid=0
rx_count  output  $clog2(DEPTH)+1  bytes currently buffered
frame_err  output  1  sticky: a stop bit was sampled low
overrun  output  1  sticky: a good byte arrived while FIFO full (byte dropped)
err_clr  input  1  clears both sticky flags

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: rx_valid=0, rx_data=8'h00, rx_count=0, frame_err=0, overrun=0, FSM=IDLE, both synchroniser flops=1, FIFO pointers=0.
- Input path: rxd passes through a 2-flop synchroniser; the FSM sees only rxd_s, which is 2 cycles late.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. Bit counter cnt counts 0..CLKS_PER_BIT-1. Bit index idx counts 0..7.
- IDLE: when rxd_s=0, go to START with cnt=0.
- START: at cnt=CLKS_PER_BIT/2-1 (integer division), sample rxd_s.
  - If 1: glitch; return to IDLE with no flag set.
  - If 0: go to DATA with cnt=0 and idx=0.
- DATA: at cnt=CLKS_PER_BIT-1, sample rxd_s into shreg[idx] (LSB first) and reset cnt. After idx=7, go to STOP.
- STOP: at cnt=CLKS_PER_BIT-1, sample rxd_s.
  - If 1: push shreg and go to IDLE.
  - If 0: set frame_err, drop the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until rxd_s=1, then go to IDLE. A held break therefore produces exactly one frame_err.
- Sampling point: every bit is sampled mid-bit, i.e. CLKS_PER_BIT/2 + k*CLKS_PER_BIT cycles after the first IDLE cycle that sees rxd_s=0 (k=1..8 for data bits, 9 for stop).
- Push latency: the stop-bit sample is taken in cycle T. The write and count update land at edge T+1, so rx_valid and rx_data are visible in cycle T+1.
- FIFO: memory plus rd/wr pointers of $clog2(DEPTH)+1 bits each. Pointers wrap naturally modulo 2*DEPTH.
  - empty when pointers are equal.
  - full when the low bits are equal and the MSBs differ.
  - rx_count = wr_ptr - rd_ptr.
  - rx_data = mem[rd_ptr] when non-empty, else 8'h00.
- Simultaneous events:
  - Push and pop, not full: both happen; count unchanged.
  - Push and pop, full: both accepted; count stays DEPTH; no overrun.
  - Push and pop, empty: pop ignored; count becomes 1.
  - Push when full without pop: byte dropped, overrun=1, FIFO contents untouched.
  - Flag set and err_clr in the same cycle: set wins.
- Reset mid-frame: rst forces IDLE and empties the FIFO. A partial frame is discarded with no flag. The receiver resynchronises on the next falling edge seen while in IDLE.

Decomposition:
- Package uart_pkg holds:
  - the FSM state enum (rx_state_t: IDLE, START, DATA, STOP, WAIT_HIGH);
  - UART_DATA_BITS=8;
  - the default CLKS_PER_BIT constant, shared with the future tx block.
- One sub-module, byte_fifo (params DEPTH, WIDTH=8):
  - inputs push, pop, din;
  - outputs dout, empty, full, count.
  - It is reused later by the tx path.

Test Plan:
All scenarios use CLKS_PER_BIT=8 and DEPTH=4.
- Reset: rxd=1, rst high 2 cycles -> rx_valid=0, rx_data=8'h00, rx_count=0, frame_err=0, overrun=0; everything stays there for 100 idle cycles.
- Single byte: send 0xA5 8N1 -> rx_valid rises exactly 1 cycle after the stop-bit sample; rx_data=8'hA5, rx_count=1. Pulse rx_pop -> next cycle rx_valid=0, rx_data=8'h00.
- Glitch: drive rxd low for 2 cycles, then high -> no push, no flag; a following 0x5A is received correctly.
- Framing: send 0x3C with stop bit 0, then hold rxd=0 for 20 bit times -> frame_err=1 once, rx_count=0. Release the line, send 0x01 -> rx_data=8'h01. err_clr -> frame_err=0.
- Overrun: send 0x11..0x15 with no pops -> rx_count=4, overrun=1. Four pops return 0x11, 0x12, 0x13, 0x14, then rx_valid=0.
- Full push+pop: fill with 0x21..0x24. Pulse rx_pop in the cycle 0x25 is pushed -> rx_count stays 4, overrun=0, pop order is 0x22, 0x23, 0x24, 0x25.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, frame size and default bit timing.
// The tx path will reuse the same constants.
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 868;  // 100 MHz / 115200 baud

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead FIFO with extra-MSB pointers; a push into a full FIFO is accepted only
// when a pop frees the head slot in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             pop_en;
  logic             push_en;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign pop_en  = pop && !empty;
  // When full, the slot being written is the one being popped this cycle.
  assign push_en = push && (!full || pop_en);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_buf.sv
// 8N1 UART receiver with mid-bit sampling feeding a byte FIFO for the core's rxdata.
// Sticky frame_err / overrun flags are cleared by err_clr; a new event wins over the clear.
module uart_rx_buf
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DEPTH        = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rxd,
  output logic [7:0]             rx_data,
  output logic                   rx_valid,
  input  logic                   rx_pop,
  output logic [$clog2(DEPTH):0] rx_count,
  output logic                   frame_err,
  output logic                   overrun,
  input  logic                   err_clr,
  output rx_state_t              dbg_state
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

  logic                      rxd_m;
  logic                      rxd_s;
  rx_state_t                 state;
  logic [CNT_W-1:0]          cnt;
  logic [IDX_W-1:0]          idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      stop_sample;
  logic                      byte_good;
  logic                      byte_bad;
  logic                      fifo_empty;
  logic                      fifo_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  // Start-bit check at half a bit, then every bit one full period later: mid-bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!rxd_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (rxd_s) begin
              state <= IDLE;
            end else begin
              state <= DATA;
              idx   <= '0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt        <= '0;
            shreg[idx] <= rxd_s;
            if (idx == IDX_LAST) begin
              state <= STOP;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= rxd_s ? IDLE : WAIT_HIGH;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_HIGH: begin
          if (rxd_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stop_sample = (state == STOP) && (cnt == CNT_LAST);
  assign byte_good   = stop_sample && rxd_s;
  assign byte_bad    = stop_sample && !rxd_s;
  assign dbg_state   = state;

  byte_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (byte_good),
    .pop   (rx_pop),
    .din   (shreg),
    .dout  (rx_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (rx_count)
  );

  assign rx_valid = !fifo_empty;

  // A pop alongside a push into a full FIFO frees a slot, so nothing is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (byte_bad)     frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (byte_good && fifo_full && !rx_pop) overrun <= 1'b1;
      else if (err_clr)                      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_buf.sv
// Bench for uart_rx_buf: serial frames are driven bit by bit and outputs are compared
// against a queue-based model of the byte buffer and its sticky flags.
module tb_uart_rx_buf;
  import uart_pkg::*;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int FRAME = 10 * CPB;
  // 2 synchroniser cycles, half bit, nine full bits, then one cycle for the write
  localparam int RISE  = 2 + CPB / 2 + 9 * CPB + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rxd = 1'b1;
  logic          rx_pop = 1'b0;
  logic          err_clr = 1'b0;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [CW-1:0] rx_count;
  logic          frame_err;
  logic          overrun;
  rx_state_t     dbg_state;

  int vectors = 0;
  int errors  = 0;
  int rise_cyc;

  logic [7:0] exp_q[$];
  logic       exp_ferr = 1'b0;
  logic       exp_ovr  = 1'b0;

  // {rx_valid, rx_data, rx_count, frame_err, overrun}
  wire [10+CW:0] obs = {rx_valid, rx_data, rx_count, frame_err, overrun};

  uart_rx_buf #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_pop    (rx_pop),
    .rx_count  (rx_count),
    .frame_err (frame_err),
    .overrun   (overrun),
    .err_clr   (err_clr),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [10+CW:0] model_status();
    logic [7:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
    return {exp_q.size() != 0, head, CW'(exp_q.size()), exp_ferr, exp_ovr};
  endfunction

  // Model of one received frame: good bytes are buffered or dropped as overrun.
  task automatic model_frame(input logic [7:0] b, input logic stop_bit, input logic popped);
    if (popped && exp_q.size() != 0) void'(exp_q.pop_front());
    if (!stop_bit)                   exp_ferr = 1'b1;
    else if (exp_q.size() < DEPTH)   exp_q.push_back(b);
    else                             exp_ovr = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drives one 8N1 frame; pop_at / clr_at pulse rx_pop / err_clr in that cycle of the frame.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int pop_at, input int clr_at);
    logic [9:0] bits;
    logic       prev;
    bits     = {stop_bit, b, 1'b0};
    rise_cyc = -1;
    prev     = rx_valid;
    for (int i = 0; i < FRAME; i++) begin
      @(posedge clk);
      #1;
      rxd     = bits[i / CPB];
      rx_pop  = (i == pop_at);
      err_clr = (i == clr_at);
      @(negedge clk);
      if (rise_cyc < 0 && rx_valid && !prev) rise_cyc = i;
      prev = rx_valid;
    end
    rx_pop  = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic do_pop();
    tick();
    rx_pop = 1'b1;
    tick();
    rx_pop = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic do_clr();
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    exp_ferr = 1'b0;
    exp_ovr  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rxd = 1'b1;
    idle(2);
    rst = 1'b0;
    exp_q.delete();
    exp_ferr = 1'b0;
    exp_ovr  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      vectors++;
      if (obs !== model_status() || dbg_state !== IDLE) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: got %h st %0d, exp %h st %0d",
                 i, obs, dbg_state, model_status(), IDLE);
      end
    end
  endtask

  task automatic test_single();
    send_frame(8'hA5, 1'b1, -1, -1);
    model_frame(8'hA5, 1'b1, 1'b0);
    vectors++;
    if (rise_cyc != RISE) begin
      errors++;
      $display("FAIL single_latency: got cycle %0d, exp %0d", rise_cyc, RISE);
    end
    @(negedge clk);
    vectors++;
    if (obs !== model_status()) begin
      errors++;
      $display("FAIL single_data: got %h, exp %h", obs, model_status());
    end
    do_pop();
    @(negedge clk);
    vectors++;
    if (obs !== model_status()) begin
      errors++;
      $display("FAIL single_pop: got %h, exp %h", obs, model_status());
    end
  endtask

  task automatic test_glitch();
    tick();
    rxd = 1'b0;
    idle(2);
    rxd = 1'b1;
    idle(3 * CPB);
    @(negedge clk);
    vectors++;
    if (obs !== model_status() || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL glitch_ignored: got %h st %0d, exp %h", obs, dbg_state, model_status());
    end
    send_frame(8'h5A, 1'b1, -1, -1);
    model_frame(8'h5A, 1'b1, 1'b0);
    idle(2);
    @(negedge clk);
    vectors++;
    if (obs !== model_status()) begin
      errors++;
      $display("FAIL glitch_next_byte: got %h, exp %h", obs, model_status());
    end
    do_pop();
  endtask

  task automatic test_framing();
    send_frame(8'h3C, 1'b0, -1, -1);
    model_frame(8'h3C, 1'b0, 1'b0);
    idle(10 * CPB);
    @(negedge clk);
    vectors++;
    if (obs !== model_status()) begin
      errors++;
      $display("FAIL frame_err_set: got %h, exp %h", obs, model_status());
    end
    // Clearing during the break must not be followed by a second framing error.
    do_clr();
    idle(10 * CPB);
    @(negedge clk);
    vectors++;
    if (obs !== model_status()) begin
      errors++;
      $display("FAIL frame_err_once: got %h, exp %h", obs, model_status());
    end
    rxd = 1'b1;
    idle(4 * CPB);
    send_frame(8'h01, 1'b1, -1, -1);
    model_frame(8'h01, 1'b1, 1'b0);
    idle(2);
    @(negedge clk);
    vectors++;
    if (obs !== model_status()) begin
      errors++;
      $display("FAIL frame_recover: got %h, exp %h", obs, model_status());
    end
    // err_clr in the stop-sample cycle: the new error must win.
    send_frame(8'h3C, 1'b0, -1, FRAME - 2);
    model_frame(8'h3C, 1'b0, 1'b0);
    rxd = 1'b1;
    idle(4);
    @(negedge clk);
    vectors++;
    if (obs !== model_status()) begin
      errors++;
      $display("FAIL frame_set_wins: got %h, exp %h", obs, model_status());
    end
    do_clr();
    @(negedge clk);
    vectors++;
    if (obs !== model_status()) begin
      errors++;
      $display("FAIL frame_clear: got %h, exp %h", obs, model_status());
    end
    do_pop();
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 5; i++) begin
      send_frame(8'h11 + 8'(i), 1'b1, -1, -1);
      model_frame(8'h11 + 8'(i), 1'b1, 1'b0);
    end
    idle(2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (obs !== model_status()) begin
        errors++;
        $display("FAIL overrun_drain %0d: got %h, exp %h", i, obs, model_status());
      end
      do_pop();
    end
    @(negedge clk);
    vectors++;
    if (obs !== model_status()) begin
      errors++;
      $display("FAIL overrun_empty_pop: got %h, exp %h", obs, model_status());
    end
    do_clr();
    @(negedge clk);
    vectors++;
    if (obs !== model_status()) begin
      errors++;
      $display("FAIL overrun_clear: got %h, exp %h", obs, model_status());
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) begin
      send_frame(8'h21 + 8'(i), 1'b1, -1, -1);
      model_frame(8'h21 + 8'(i), 1'b1, 1'b0);
    end
    send_frame(8'h25, 1'b1, FRAME - 2, -1);
    model_frame(8'h25, 1'b1, 1'b1);
    idle(2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (obs !== model_status()) begin
        errors++;
        $display("FAIL full_push_pop %0d: got %h, exp %h", i, obs, model_status());
      end
      do_pop();
    end
  endtask

  task automatic test_reset_mid();
    send_frame(8'h77, 1'b1, -1, -1);
    model_frame(8'h77, 1'b1, 1'b0);
    tick();
    rxd = 1'b0;
    idle(3 * CPB);
    rxd = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    idle(2 * CPB);
    @(negedge clk);
    vectors++;
    if (obs !== model_status() || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_mid_frame: got %h st %0d, exp %h", obs, dbg_state, model_status());
    end
    send_frame(8'h96, 1'b1, -1, -1);
    model_frame(8'h96, 1'b1, 1'b0);
    idle(2);
    @(negedge clk);
    vectors++;
    if (obs !== model_status()) begin
      errors++;
      $display("FAIL reset_resync: got %h, exp %h", obs, model_status());
    end
    do_pop();
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       good;
    int         npop;
    for (int n = 0; n < 16; n++) begin
      b    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 5) != 0);
      send_frame(b, good, -1, -1);
      model_frame(b, good, 1'b0);
      rxd = 1'b1;
      idle($urandom_range(3, 2 * CPB));
      @(negedge clk);
      vectors++;
      if (obs !== model_status()) begin
        errors++;
        $display("FAIL random_frame %0d (%h stop %b): got %h, exp %h",
                 n, b, good, obs, model_status());
      end
      npop = $urandom_range(0, 2);
      for (int p = 0; p < npop; p++) begin
        do_pop();
        @(negedge clk);
        vectors++;
        if (obs !== model_status()) begin
          errors++;
          $display("FAIL random_pop %0d.%0d: got %h, exp %h", n, p, obs, model_status());
        end
      end
    end
    do_clr();
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_framing();
    test_overrun();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
